div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 113 +++++++++++
 tb/tb_div_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider, signed or unsigned.
// result_o = {remainder, quotient}; one quotient bit is produced per cycle.
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   // state  | meaning
   // FREE   | idle, waiting for start_i
   // BYZERO | divisor was zero, result is forced to 0
   // ON     | iterating, one quotient bit per cycle
   // END    | result valid, held until start_i drops
   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [31:0] rem;
   logic [31:0] dq;
   logic [31:0] divisor;
   logic        neg_q;
   logic        neg_r;

   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [32:0] partial;
   logic        ge;
   logic [31:0] rem_next;

   assign mag_a = (signed_div_i && opdata1_i[31]) ? 32'd0 - opdata1_i : opdata1_i;
   assign mag_b = (signed_div_i && opdata2_i[31]) ? 32'd0 - opdata2_i : opdata2_i;

   // The 33-bit compare decides the quotient bit; when it succeeds the true
   // difference is below the divisor, so the low 32 bits carry it exactly.
   assign partial  = {rem, dq[31]};
   assign ge       = (partial >= {1'b0, divisor});
   assign rem_next = ge ? partial[31:0] - divisor : partial[31:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FREE;
         cnt      <= 6'd0;
         rem      <= 32'd0;
         dq       <= 32'd0;
         divisor  <= 32'd0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         ready_o  <= 1'b0;
         result_o <= 64'd0;
      end else begin
         case (state)
            FREE: begin
               ready_o  <= 1'b0;
               result_o <= 64'd0;
               if (start_i && !annul_i) begin
                  dq      <= mag_a;
                  divisor <= mag_b;
                  rem     <= 32'd0;
                  cnt     <= 6'd0;
                  neg_q   <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                  neg_r   <= signed_div_i && opdata1_i[31];
                  state   <= (opdata2_i == 32'd0) ? BYZERO : ON;
               end
            end
            BYZERO: begin
               result_o <= 64'd0;
               if (annul_i) begin
                  ready_o <= 1'b0;
                  state   <= FREE;
               end else begin
                  ready_o <= 1'b1;
                  state   <= END;
               end
            end
            ON: begin
               if (annul_i) begin
                  cnt      <= 6'd0;
                  rem      <= 32'd0;
                  dq       <= 32'd0;
                  ready_o  <= 1'b0;
                  result_o <= 64'd0;
                  state    <= FREE;
               end else if (cnt == 6'd32) begin
                  result_o <= {neg_r ? 32'd0 - rem : rem,
                               neg_q ? 32'd0 - dq  : dq};
                  ready_o  <= 1'b1;
                  state    <= END;
               end else begin
                  rem <= rem_next;
                  dq  <= {dq[30:0], ge};
                  cnt <= cnt + 6'd1;
               end
            end
            END: begin
               if (!start_i) begin
                  ready_o  <= 1'b0;
                  result_o <= 64'd0;
                  cnt      <= 6'd0;
                  state    <= FREE;
               end
            end
            default: state <= FREE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by
// zero, annul, overflow case and synchronous reset during an operation.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a request, corrupt operands after acceptance, measure latency,
   // check hold (with annul ignored) in END, then release.
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int lat, input logic [63:0] exp);
      int n;
      logic [63:0] res;
      opdata1_i    = a;
      opdata2_i    = b;
      signed_div_i = s;
      start_i      = 1'b1;
      n = 0;
      while (n < 40) begin
         tick();
         n++;
         if (n == 1) begin
            opdata1_i    = ~a;
            opdata2_i    = b + 32'd3;
            signed_div_i = ~s;
         end
         if (ready_o) break;
      end
      if (!ready_o) n = 99;
      check({tag, "_latency"}, 64'(n), 64'(lat));
      check({tag, "_result"}, result_o, exp);
      res = result_o;
      annul_i = 1'b1;
      tick();
      annul_i = 1'b0;
      check({tag, "_hold"}, {ready_o, result_o}, {1'b1, res});
      start_i = 1'b0;
      tick();
      check({tag, "_release"}, {ready_o, result_o}, 65'd0);
   endtask

   initial begin
      int n;
      logic seen;
      rst          = 1'b1;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = 32'd0;
      opdata2_i    = 32'd0;
      tick();
      tick();
      check("reset_state", {ready_o, result_o}, 65'd0);
      rst = 1'b0;
      tick();

      run_div("u_100_7", 32'd100, 32'd7, 1'b0, 34, {32'd2, 32'd14});
      run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 34, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 34, {32'h0000_0001, 32'hFFFF_FFFD});
      run_div("u_5_0", 32'd5, 32'd0, 1'b0, 2, 64'd0);
      run_div("s_5_0", 32'd5, 32'd0, 1'b1, 2, 64'd0);

      // annul at cnt=10: cnt is 10 after edge 11, annul seen at edge 12
      opdata1_i    = 32'h1234_5678;
      opdata2_i    = 32'd3;
      signed_div_i = 1'b0;
      start_i      = 1'b1;
      for (int i = 0; i < 11; i++) tick();
      annul_i = 1'b1;
      start_i = 1'b0;
      tick();
      annul_i = 1'b0;
      check("annul_free", {ready_o, result_o}, 65'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ready_o) seen = 1'b1;
      end
      check("annul_no_ready", 64'(seen), 64'd0);

      run_div("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 34, {32'd0, 32'hFFFF_FFFF});
      run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 34, {32'd0, 32'h8000_0000});

      // reset at cnt=20 (after edge 21) with start held
      opdata1_i    = 32'd1000;
      opdata2_i    = 32'd7;
      signed_div_i = 1'b0;
      start_i      = 1'b1;
      for (int i = 0; i < 21; i++) tick();
      rst = 1'b1;
      tick();
      check("rst_mid_op", {ready_o, result_o}, 65'd0);
      rst = 1'b0;
      n = 0;
      while (n < 40) begin
         tick();
         n++;
         if (ready_o) break;
      end
      if (!ready_o) n = 99;
      check("rst_restart_latency", 64'(n), 64'd34);
      check("rst_restart_result", result_o, {32'd6, 32'd142});
      start_i = 1'b0;
      tick();
      check("rst_restart_release", {ready_o, result_o}, 65'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
